reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Read-side companion to the 32x32 register file.
- On Start, walks register addresses 0..NUM_REGS-1 through a read port: drives the address, captures the combinational read data, and presents each {address, data} pair on a valid/ready output stream.
- Used to dump architectural state to the seven-segment/LED display mux or a debug UART after a program halts.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers walked; must be <= 2**ADDR_W.
- SKIP_ZERO, 0, when 1 the walk starts at address 1 (register 0 is hardwired zero).

Ports:
- Clk  input  1  single clock; all state on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  level-sampled; begins a dump when in IDLE.
- Abort  input  1  synchronous; terminates a dump in progress.
- Busy  output  1  high from the cycle after Start accept until return to IDLE.
- Done  output  1  one-cycle pulse after the last pair is accepted.
- R_Addr  output  ADDR_W  address to the register file read port (A or B).
- R_Data  input  DATA_W  combinational read data from the register file.
- Out_Valid  output  1  output pair available.
- Out_Ready  input  1  consumer accepts the pair.
- Out_Addr  output  ADDR_W  register index of the presented pair.
- Out_Data  output  DATA_W  captured register value.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All outputs are 0: Busy, Done, Out_Valid, R_Addr, Out_Addr, Out_Data.
  - State is IDLE; index counter is 0.
- States: IDLE, READ, PRESENT, FIN.
- IDLE:
  - R_Addr = 0.
  - Start=1 loads idx = (SKIP_ZERO ? 1 : 0) and moves to READ.
  - Busy rises on the next edge.
- READ (exactly 1 cycle):
  - R_Addr = idx.
  - On the edge: Out_Data <= R_Data, Out_Addr <= idx, Out_Valid <= 1, move to PRESENT.
- PRESENT:
  - Out_Valid=1; Out_Addr/Out_Data held stable until the handshake.
  - A transfer occurs on an edge with Out_Valid && Out_Ready.
  - On transfer, if idx == NUM_REGS-1 → FIN; else idx <= idx+1 and → READ.
  - Out_Valid drops on the transfer edge.
- FIN (1 cycle): Done=1 for this cycle, Busy=0, then → IDLE.
- Throughput: 2 cycles per register minimum (READ + PRESENT with Ready already high). A full 32-register dump with Ready tied high takes 64 cycles from the first READ plus 1 FIN cycle.
- Out_Ready low stalls indefinitely in PRESENT with no data change.
- Start while Busy is ignored. Start held high through FIN re-triggers a new dump from IDLE on the following cycle.
- Abort (any non-IDLE state, highest priority over handshake):
  - Next edge: state=IDLE, Out_Valid=0, Busy=0, no Done pulse.
  - A same-cycle Out_Ready does not count as a transfer.
- Consistency: values are sampled at each READ cycle. Writes by the datapath during a dump are visible for higher addresses not yet read. The dump is meant to run while the CPU is halted; it does not enforce this.
- Counter width is ADDR_W+1 internally, so NUM_REGS = 2**ADDR_W does not wrap before the compare.
- Reset_n asserted mid-dump: immediate return to the reset values; no Done.

Decomposition:
- Shared package (regfile_pkg):
  - state encoding constants S_IDLE=2'd0, S_READ=2'd1, S_PRESENT=2'd2, S_FIN=2'd3;
  - REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32 shared with the register file.
- No sub-module. FSM, index counter and capture register are one module. The bench instantiates the existing register file with R_Addr on read port A.

Test Plan:
- Preload reg[i]=32'h1000_0000+i via the write port, Out_Ready=1, pulse Start → 32 transfers, Out_Addr 0..31, Out_Data 32'h1000_0000..32'h1000_001F; Done pulses once, 65 cycles after the first READ.
- SKIP_ZERO=1, same preload → exactly 31 transfers, first Out_Addr=1 with Out_Data=32'h1000_0001.
- Out_Ready toggled 0 for 5 cycles at register 7 (data 32'hDEAD_BEEF) → Out_Valid stays 1, Out_Addr=7, Out_Data=32'hDEAD_BEEF held stable; the dump then resumes at 8.
- Abort asserted in PRESENT at register 12 with Out_Ready=1 the same cycle → no transfer counted, next cycle Busy=0, Out_Valid=0, no Done; a new Start restarts at 0.
- Start re-pulsed at register 4 → ignored, addresses continue 5,6,…; Reset_n pulled low at register 20 → all outputs 0 immediately (asynchronously), state IDLE.
- Write reg[30]=32'h0000_ABCD via the write port while the dump is stalled at register 10 → register 30 later reports 32'h0000_ABCD.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file geometry and dump reader state encoding
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_FIN     = 2'd3;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file read port and streams {addr, data} pairs
module reg_dump_reader
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int NUM_REGS  = REG_COUNT,
    parameter int SKIP_ZERO = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_r_addr,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data
);

    // One spare bit so NUM_REGS == 2**ADDR_W cannot wrap before the last-index compare.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? CNT_W'(1) : '0;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_idx;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;

    logic [ADDR_W-1:0] w_idx_addr;

    assign w_idx_addr = r_idx[ADDR_W-1:0];

    // Walk FSM: abort wins over everything, including a same-cycle handshake.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_idx   <= FIRST_IDX;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_out_data  <= i_r_data;
                    r_out_addr  <= w_idx_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and read address decode directly from state so reset clears them immediately.
    always_comb begin
        o_busy   = (r_state == S_READ) || (r_state == S_PRESENT);
        o_done   = (r_state == S_FIN);
        o_r_addr = (r_state == S_READ) ? w_idx_addr : '0;
    end

    assign o_out_valid = r_out_valid;
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;

    localparam int NR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic        ready;
    logic        sel;

    logic [31:0] rf  [NR];
    logic [31:0] mdl [NR];

    logic        busy0, done0, valid0, busy1, done1, valid1;
    logic [4:0]  raddr0, oaddr0, raddr1, oaddr1;
    logic [31:0] rdata0, odata0, rdata1, odata1;

    assign rdata0 = rf[raddr0];
    assign rdata1 = rf[raddr1];

    reg_dump_reader #(.SKIP_ZERO(0)) u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start & ~sel), .i_abort(abort & ~sel),
        .o_busy(busy0), .o_done(done0), .o_r_addr(raddr0), .i_r_data(rdata0),
        .o_out_valid(valid0), .i_out_ready(ready), .o_out_addr(oaddr0), .o_out_data(odata0)
    );

    reg_dump_reader #(.SKIP_ZERO(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start & sel), .i_abort(abort & sel),
        .o_busy(busy1), .o_done(done1), .o_r_addr(raddr1), .i_r_data(rdata1),
        .o_out_valid(valid1), .i_out_ready(ready), .o_out_addr(oaddr1), .o_out_data(odata1)
    );

    logic        o_busy, o_done, o_valid;
    logic [4:0]  o_oaddr;
    logic [31:0] o_odata;

    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;
    assign o_valid = sel ? valid1 : valid0;
    assign o_oaddr = sel ? oaddr1 : oaddr0;
    assign o_odata = sel ? odata1 : odata0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic rf_write(input int a, input logic [31:0] d);
        rf[a]  = d;
        mdl[a] = d;
    endtask

    task automatic preload_pattern();
        for (int i = 0; i < NR; i++) rf_write(i, 32'h1000_0000 + 32'(i));
    endtask

    task automatic preload_random();
        for (int i = 0; i < NR; i++) rf_write(i, $urandom);
    endtask

    // Full dump: every accepted pair must be the next address in order carrying the
    // bench's register contents at that moment; ends with exactly one Done.
    task automatic run_dump(input bit which, input int first, input bit rnd_ready,
                            input int stall_addr, input int stall_len,
                            input int wr_addr, input logic [31:0] wr_data,
                            input int repulse_at, input bit timed);
        int  exp_addr;
        int  cyc;
        int  stall_cnt;
        bit  got_done;
        exp_addr  = first;
        cyc       = 0;
        stall_cnt = 0;
        got_done  = 0;
        sel   = which;
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 600 && !got_done; k++) begin
            if (o_busy || o_done) cyc++;
            if (o_done) begin
                got_done = 1;
                chk("busy_low_in_fin", o_busy, 0);
                chk("pairs_transferred", exp_addr - first, NR - first);
                if (timed) chk("dump_cycles", cyc, 2 * (NR - first) + 1);
            end
            start = 1'b0;
            if (o_valid && o_oaddr == stall_addr[4:0] && stall_cnt < stall_len) begin
                ready = 1'b0;
                chk("stall_valid", o_valid, 1);
                chk("stall_addr", o_oaddr, stall_addr);
                chk("stall_data", o_odata, mdl[stall_addr]);
                stall_cnt++;
                if (stall_cnt == 2 && wr_addr >= 0) rf_write(wr_addr, wr_data);
            end else begin
                ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (repulse_at >= 0 && o_valid && o_oaddr == repulse_at[4:0]) start = 1'b1;
            if (o_valid && ready) begin
                chk("out_addr", o_oaddr, exp_addr);
                chk("out_data", o_odata, mdl[exp_addr]);
                exp_addr++;
            end
            @(negedge clk);
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("done_single_pulse", o_done, 0);
        chk("idle_after_fin", o_busy, 0);
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic wait_present(input int a, output bit ok);
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (o_valid && o_oaddr == a[4:0]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) chk("wait_present_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        sel   = 1'b0;
        for (int i = 0; i < NR; i++) begin rf[i] = '0; mdl[i] = '0; end
        #1;
        chk("rst_busy",  {busy0, busy1}, 0);
        chk("rst_done",  {done0, done1}, 0);
        chk("rst_valid", {valid0, valid1}, 0);
        chk("rst_raddr", {raddr0, raddr1}, 0);
        chk("rst_oaddr", {oaddr0, oaddr1}, 0);
        chk("rst_odata", {odata0, odata1}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed pattern, Ready tied high: full ordered walk with exact cycle count.
        preload_pattern();
        run_dump(0, 0, 0, -1, 0, -1, 0, -1, 1);

        // Register 0 skipped: 31 pairs starting at address 1.
        run_dump(1, 1, 0, -1, 0, -1, 0, -1, 1);

        // Consumer stall at register 7 holds the presented pair.
        rf_write(7, 32'hDEAD_BEEF);
        run_dump(0, 0, 0, 7, 5, -1, 0, -1, 0);

        // Datapath write during a stall at 10 is visible when 30 is read later.
        preload_pattern();
        run_dump(0, 0, 0, 10, 4, 30, 32'h0000_ABCD, -1, 0);

        // Start pulsed mid-dump is ignored; walk continues in order.
        run_dump(0, 0, 0, -1, 0, -1, 0, 4, 1);

        // Abort in PRESENT at 12 with Ready high: no transfer, no Done.
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_present(12, ok);
        abort = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",  o_busy, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_done",  o_done, 0);
        @(negedge clk);
        chk("abort_no_done_later", o_done, 0);
        run_dump(0, 0, 0, -1, 0, -1, 0, -1, 1);

        // Asynchronous reset at register 20 clears outputs before the next edge.
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_present(20, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  o_busy, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_done",  o_done, 0);
        chk("arst_raddr", raddr0, 0);
        chk("arst_oaddr", o_oaddr, 0);
        chk("arst_odata", o_odata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", o_busy, 0);

        // Random contents with random consumer backpressure on both variants.
        for (int r = 0; r < 3; r++) begin
            preload_random();
            run_dump(0, 0, 1, -1, 0, -1, 0, -1, 0);
            run_dump(1, 1, 1, -1, 0, -1, 0, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
